lcd_bus_scheduler: RTL

- Owns the shared HD44780-style character-LCD bus (RS/RW/EN/DATA[7:0]).
- Runs the power-on init sequence, then arbitrates write requests from two requesters, e.g. a command source and a data source.
- Generates EN setup/pulse/hold timing and the post-write busy wait by counters; sits between the user-facing LCD logic and the board LCD pins.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_bus_scheduler_if.sv | 10 +
 rtl/lcd_rr_arbiter.sv | 34 +++
 rtl/lcd_bus_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus scheduler.
package lcd_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
  endfunction

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] val;
    case (idx)
      2'd0:    val = LCD_FUNC_SET;
      2'd1:    val = LCD_DISP_ON;
      2'd2:    val = LCD_CLEAR;
      2'd3:    val = LCD_ENTRY;
      default: val = LCD_FUNC_SET;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// Write-request handshake between the two LCD requesters and the scheduler.
interface lcd_bus_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_ack;

  modport master (output req_valid, output req_rs, output req_data, input req_ack);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ack);
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter; priority passes to the requester not granted last.
module lcd_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_any
);

  logic prio_r;

  // Combinational grant selection
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = prio_r ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  assign grant_any = |req;

  // Priority pointer, moved only when a grant is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (advance && grant_any) begin
      prio_r <= grant[0];
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Owns the HD44780 bus: power-up init, round-robin write arbitration, EN timing.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 4,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned PWRUP_CYC    = 750000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  lcd_bus_scheduler_if.slave   req,
  output logic                 busy,
  output logic                 init_done,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic [7:0]           LCD_DATA
);

  lcd_state_e       state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, limit_s;
  logic             cnt_done_s;
  logic [1:0]       idx_r;
  logic             init_done_r, rs_r, en_r, busy_r;
  logic [7:0]       data_r;
  logic [1:0]       ack_r, ack_s, grant_s;
  logic             grant_any_s, take_s, load_s, ld_rs_s, idx_inc_s, done_set_s;
  logic [7:0]       ld_data_s;

  assign take_s = (state_r == ST_IDLE) && init_done_r && grant_any_s;

  lcd_rr_arbiter u_arb (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .req       (req.req_valid),
    .advance   (take_s),
    .grant     (grant_s),
    .grant_any (grant_any_s)
  );

  // Dwell length of the current state
  always_comb begin
    limit_s = {{(CNT_W-1){1'b0}}, 1'b1};
    case (state_r)
      ST_PWRUP: limit_s = CNT_W'(PWRUP_CYC);
      ST_SETUP: limit_s = CNT_W'(SETUP_CYC);
      ST_PULSE: limit_s = CNT_W'(EN_CYC);
      ST_HOLD:  limit_s = CNT_W'(HOLD_CYC);
      ST_WAIT:  limit_s = is_long_cmd(rs_r, data_r) ? CNT_W'(CLR_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
      default:  limit_s = {{(CNT_W-1){1'b0}}, 1'b1};
    endcase
  end

  assign cnt_done_s = (cnt_r == (limit_s - {{(CNT_W-1){1'b0}}, 1'b1}));

  // State register and dwell counter (counter restarts on every state change)
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_PWRUP;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= (next_state_s != state_r) ? '0 : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_PWRUP:     next_state_s = cnt_done_s ? ST_INIT_LOAD : ST_PWRUP;
      ST_INIT_LOAD: next_state_s = ST_SETUP;
      ST_SETUP:     next_state_s = cnt_done_s ? ST_PULSE : ST_SETUP;
      ST_PULSE:     next_state_s = cnt_done_s ? ST_HOLD : ST_PULSE;
      ST_HOLD:      next_state_s = cnt_done_s ? ST_WAIT : ST_HOLD;
      ST_WAIT: begin
        if (!cnt_done_s) begin
          next_state_s = ST_WAIT;
        end else if (!init_done_r && (idx_r != 2'd3)) begin
          next_state_s = ST_INIT_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_IDLE:      next_state_s = take_s ? ST_SETUP : ST_IDLE;
      default:      next_state_s = ST_PWRUP;
    endcase
  end

  // Per-state actions: latch loads, acks, init bookkeeping
  always_comb begin
    ack_s      = 2'b00;
    load_s     = 1'b0;
    ld_rs_s    = 1'b0;
    ld_data_s  = 8'h00;
    idx_inc_s  = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      ST_INIT_LOAD: begin
        load_s    = 1'b1;
        ld_data_s = init_rom(idx_r);
      end
      ST_WAIT: begin
        if (cnt_done_s && !init_done_r) begin
          idx_inc_s  = (idx_r != 2'd3);
          done_set_s = (idx_r == 2'd3);
        end else begin
          idx_inc_s  = 1'b0;
          done_set_s = 1'b0;
        end
      end
      ST_IDLE: begin
        if (take_s) begin
          load_s    = 1'b1;
          ack_s     = grant_s;
          ld_rs_s   = grant_s[1] ? req.req_rs[1] : req.req_rs[0];
          ld_data_s = grant_s[1] ? req.req_data[15:8] : req.req_data[7:0];
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and write latch; EN/busy follow the upcoming state
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_r       <= 2'b00;
      en_r        <= 1'b0;
      busy_r      <= 1'b1;
      rs_r        <= 1'b0;
      data_r      <= 8'h00;
      idx_r       <= 2'd0;
      init_done_r <= 1'b0;
    end else begin
      ack_r  <= ack_s;
      en_r   <= (next_state_s == ST_PULSE);
      busy_r <= (next_state_s != ST_IDLE);
      if (load_s) begin
        rs_r   <= ld_rs_s;
        data_r <= ld_data_s;
      end
      if (idx_inc_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (done_set_s) begin
        init_done_r <= 1'b1;
      end
    end
  end

  assign req.req_ack = ack_r;
  assign busy        = busy_r;
  assign init_done   = init_done_r;
  assign LCD_RS      = rs_r;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_r;
  assign LCD_DATA    = data_r;

endmodule
